// File: rtl/bcd_seg7_pkg.sv
// bcd_seg7_pkg: shared constants and types for the multiplexed 3-digit seven-segment display.
// Holds the digit count and width, the active-low segment patterns ({g,f,e,d,c,b,a}),
// and the 7-bit segment vector type.
package bcd_seg7_pkg;
    localparam int NUM_DIGITS = 3;
    localparam int DIGIT_W    = 4;
    typedef logic [6:0] seg7_t;
    localparam seg7_t SEG_0     = 7'h40;
    localparam seg7_t SEG_1     = 7'h79;
    localparam seg7_t SEG_2     = 7'h24;
    localparam seg7_t SEG_3     = 7'h30;
    localparam seg7_t SEG_4     = 7'h19;
    localparam seg7_t SEG_5     = 7'h12;
    localparam seg7_t SEG_6     = 7'h02;
    localparam seg7_t SEG_7     = 7'h78;
    localparam seg7_t SEG_8     = 7'h00;
    localparam seg7_t SEG_9     = 7'h10;
    localparam seg7_t SEG_DASH  = 7'h3F;
    localparam seg7_t SEG_BLANK = 7'h7F;
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD digit to active-low seven-segment pattern.
// Ports: code - 4-bit digit code in; seg - 7-bit active-low {g,f,e,d,c,b,a} out.
// Codes 10..15 are not valid BCD and show a dash.
module bcd_to_seg7
    import bcd_seg7_pkg::*;
(
    input  logic [DIGIT_W-1:0] code,
    output seg7_t              seg
);
    always_comb begin
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/bcd_seg7_scan.sv
// bcd_seg7_scan: scans a 3-digit BCD value onto a multiplexed common-anode display.
// Ports: Clk - clock; Rst_n - async active-low reset; Bcd[11:0] - {hundreds,tens,units};
//        Cout - counter carry-out, lights the hundreds DP for OVF_FRAMES frames;
//        Sel[2:0] - active-low digit enable (bit0 units); Seg[7:0] - active-low {dp,g..a}.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zeros in hundreds/tens.
module bcd_seg7_scan
    import bcd_seg7_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int OVF_FRAMES = 100
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] Bcd,
    input  logic                          Cout,
    output logic [NUM_DIGITS-1:0]         Sel,
    output logic [7:0]                    Seg
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int OW = $clog2(OVF_FRAMES + 1);
    localparam logic [1:0] LAST = 2'(NUM_DIGITS - 1);

    logic [PW-1:0]                 presc;
    logic [1:0]                    idx;
    logic [NUM_DIGITS*DIGIT_W-1:0] snap;
    logic [OW-1:0]                 ovf_hold;
    logic                          tick;
    logic [DIGIT_W-1:0]            code;
    seg7_t                         dec;
    seg7_t                         pat;

    assign tick = presc == PW'(SCAN_DIV - 1);

    // Units comes straight from the input on the frame-start slot, where the snapshot is
    // also captured; tens and hundreds read the snapshot so a frame is never torn.
    assign code = idx == 2'd0 ? Bcd[3:0] : idx == 2'd1 ? snap[7:4] : snap[11:8];

    bcd_to_seg7 u_dec (.code(code), .seg(dec));

`ifdef LEADING_ZERO_BLANK_EN
    logic blank;
    assign blank = idx == 2'd2 ? snap[11:8] == 4'd0 : idx == 2'd1 ? snap[11:4] == 8'd0 : 1'b0;
    assign pat   = blank ? SEG_BLANK : dec;
`else
    assign pat = dec;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            presc    <= '0;
            idx      <= '0;
            snap     <= '0;
            ovf_hold <= '0;
            Sel      <= '1;
            Seg      <= 8'hFF;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                Sel <= ~(NUM_DIGITS'(1) << idx);
                Seg <= {~(idx == LAST && ovf_hold != '0), pat};
                idx <= idx == LAST ? 2'd0 : idx + 2'd1;
                if (idx == 2'd0)
                    snap <= Bcd;
            end
            // A fresh carry-out outranks the frame-end countdown on the same edge.
            if (Cout)
                ovf_hold <= OW'(OVF_FRAMES);
            else if (tick && idx == LAST && ovf_hold != '0)
                ovf_hold <= ovf_hold - OW'(1);
        end
    end
endmodule

// File: doc/bcd_seg7_scan.md
Name: bcd_seg7_scan

Overview:
Downstream consumer of the 3-digit BCD counter. Takes the 12-bit BCD value and the carry-out strobe, and drives a multiplexed 3-digit common-anode seven-segment display. Scanning is time-divided, with one digit active at a time. A snapshot is taken once per frame so the display never shows a torn value. A carry-out event lights the MSD decimal point for a programmable number of frames.

Parameters:
SCAN_DIV, 50000, clocks per digit slot (1 kHz digit rate at 50 MHz); legal range >= 2.
OVF_FRAMES, 100, number of full frames the overflow DP stays lit after a Cout pulse; legal range >= 1.

Ports:
Clk  input  1  system clock, rising edge.
Rst_n  input  1  asynchronous active-low reset.
Bcd  input  12  BCD value: [3:0] units, [7:4] tens, [11:8] hundreds.
Cout  input  1  counter carry-out, sampled every clock, any width.
Sel  output  3  digit enable, active-low, one-hot-zero: bit0 = units, bit2 = hundreds.
Seg  output  8  segments, active-low: [6:0] = {g,f,e,d,c,b,a}, [7] = dp.

Behaviour:
- Clock and reset: one clock, Clk. Rst_n is asynchronous and active-low.
- Reset values: Sel = 3'b111 (all off), Seg = 8'hFF, prescaler = 0, digit index idx = 0, snapshot = 12'h000, ovf_hold = 0.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. tick = (prescaler == SCAN_DIV-1).
  - The first tick is on the SCAN_DIV-th rising edge after Rst_n deasserts.
- On each tick (all outputs registered; they update on the tick edge):
  - Sel <= all ones except bit idx = 0.
  - Seg[6:0] <= decode(digit idx). Digit source:
    - idx == 0: use live Bcd[3:0], and snapshot <= Bcd in the same edge (frame start).
    - idx == 1 or 2: use snapshot.
  - idx advances 0 -> 1 -> 2 -> 0.
- Between ticks, Sel and Seg hold their values.
- Decode table (active-low [6:0]): 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10 (hex).
  - Digit codes 10..15 (invalid BCD) show a dash, 3F.
- Overflow DP:
  - Cout = 1 on any clock loads ovf_hold <= OVF_FRAMES.
  - On a tick with idx == 2 (frame end), ovf_hold decrements if nonzero.
  - If a load and a decrement fall on the same edge, the load wins.
  - Seg[7] = 0 only when the displayed digit is idx 2 and ovf_hold != 0 at the tick edge; otherwise Seg[7] = 1.
- Mid-frame Bcd changes: tens and hundreds come from the snapshot, so a frame always shows one coherent value.
- Reset asserted mid-operation: all state returns immediately (asynchronously) to the reset values. The display is dark until the next tick.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- With the macro defined:
  - Hundreds digit is blanked when its code is 0.
  - Tens digit is blanked when both hundreds and tens are 0.
  - Units is never blanked.
  - A blanked digit drives Seg[6:0] = 7F; the DP rule still applies, so hundreds can read Seg = 8'h7F.
  - Sel is still scanned normally.
- Without the macro: zeros always display as 40.

Decomposition:
- Package bcd_seg7_pkg holds:
  - NUM_DIGITS = 3 and the digit width of 4;
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - a typedef for the 7-bit segment vector.
- Sub-module bcd_to_seg7: purely combinational, 4-bit code in, 7-bit active-low pattern out, and the dash rule for codes above 9.
- The top block holds the prescaler, idx, snapshot, ovf_hold, the blanking logic and the output registers.

Test Plan:
- Reset: hold Rst_n = 0 with SCAN_DIV = 4 -> Sel = 111, Seg = FF. Release -> first tick at the 4th edge gives Sel = 110, Seg = C0, since Bcd = 0 and dp is off.
- Scan order: Bcd = 12'h359, SCAN_DIV = 4 -> successive ticks give (Sel, Seg) = (110, 90), (101, 92), (011, B0), then repeat.
- Tearing: change Bcd from 12'h199 to 12'h200 just after the units slot -> tens/hundreds still show 9/1 that frame; the next frame shows 0/0/2.
- Invalid code: Bcd = 12'h0A3 -> tens slot Seg = BF (dash).
- Overflow: OVF_FRAMES = 2, single-cycle Cout pulse -> the hundreds slot has Seg[7] = 0 for exactly 2 frames. A second Cout arriving on a frame-end edge reloads the count to 2.
- LEADING_ZERO_BLANK_EN, Bcd = 12'h007 -> hundreds and tens slots show Seg = FF, units shows F8. Bcd = 12'h070 -> hundreds FF, tens F8, units C0.
